// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver with a small output buffer.
//
// The serial line is synchronized, framed by a five-state FSM that samples
// every bit at its centre, and completed bytes are pushed into a buffer that
// the consumer drains with an o_valid/i_ready handshake.
//
// Build option:
//   UART_RX_FIFO_EN  undefined -> single holding register (full = o_valid)
//   UART_RX_FIFO_EN  defined   -> 4-entry FIFO with wrapping pointers
`timescale 1ns/1ps

module uart_receiver #(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 9600
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  // Clocks per bit and the half-bit offset used to land on bit centres.
  localparam int DIV   = clk_freq_hz / baud_rate;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] RELOAD_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] RELOAD_HALF = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchronizer
  // ---------------------------------------------------------------------------
  logic [1:0] r_sync;
  logic       w_rxs;

  // Two-flop synchronizer; flops reset to the idle (high) line level so a
  // reset release never looks like a start bit.
  // NOTE: clocked state is always written with non-blocking (<=) assignments
  // so every flop samples the pre-edge values of its inputs, independent of
  // statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
    end
  end

  assign w_rxs = r_sync[1];

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_cnt_zero;
  logic             w_push;
  logic             w_frame_err;

  assign w_cnt_zero = (r_cnt == '0);

  // State, bit-timer, bit index and shift register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Next-state logic: the down-counter times each half/full bit, and every
  // decision is taken only when it reaches zero.
  // NOTE: every signal driven here receives a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_frame_err = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = RELOAD_HALF;
        end
      end

      S_START: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_rxs) begin
          // Line went back high before mid start bit: treat as a glitch.
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = RELOAD_FULL;
          w_idx_nxt   = 3'd0;
        end
      end

      S_DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          // LSB arrives first, so shift in from the top; after eight samples
          // bit 0 sits in the LSB.
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_cnt_nxt   = RELOAD_FULL;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_rxs) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          // Stop bit low: drop the byte and wait out any break condition.
          w_frame_err = 1'b1;
          w_state_nxt = S_WAIT_HIGH;
        end
      end

      S_WAIT_HIGH: begin
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  logic w_pop;
  logic w_full;
  logic w_accept;
  logic w_overrun;

  assign w_pop     = o_valid & i_ready;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign w_accept  = w_push & (~w_full | w_pop);
  assign w_overrun = w_push & w_full & ~w_pop;

`ifdef UART_RX_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;

  assign w_full  = (r_count == 3'd4);
  assign o_valid = (r_count != 3'd0);
  assign o_data  = r_mem[r_rd_ptr];

  // FIFO storage, wrapping pointers and occupancy count.
  // NOTE: the four storage bytes are reset on purpose: o_data reads the head
  // entry directly and must be 0x00 while in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  logic [7:0] r_hold_data;
  logic       r_hold_valid;

  assign w_full  = r_hold_valid;
  assign o_valid = r_hold_valid;
  assign o_data  = r_hold_data;

  // Single holding register; data is only replaced by an accepted push, so
  // o_data stays put while the consumer stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_data  <= r_shift;
      r_hold_valid <= 1'b1;
    end else if (w_pop) begin
      r_hold_valid <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Status pulses
  // ---------------------------------------------------------------------------
  logic r_frame_err;
  logic r_overrun;

  // Register the error strobes into clean one-cycle output pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
    end
  end

  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter clk_freq_hz, default 12000000, system clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 9600, line bit rate; DIV = clk_freq_hz/baud_rate (integer, 1250 at defaults).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_rxd  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port o_data  output  8  received byte at buffer head.
REQ-007 SHALL have port o_valid  output  1  buffer holds at least one byte.
REQ-008 SHALL have port i_ready  input  1  consumer accepts o_data this cycle.
REQ-009 SHALL have port o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port o_overrun  output  1  one-cycle pulse, complete byte dropped because buffer full.

Function
REQ-011 SHALL pass i_rxd through a 2-flop synchronizer; all decisions use synchronized value rxs.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with one down-counter cnt and bit index 0..7.
REQ-013 IDLE: rxs==0 -> START, cnt = DIV/2-1.
REQ-014 START: at cnt==0, rxs==1 -> IDLE silently (glitch, no error pulse); rxs==0 -> DATA, cnt = DIV-1, index 0.
REQ-015 DATA: at each cnt==0 sample rxs into bit[index], LSB first, reload DIV-1; after index 7 -> STOP.
REQ-016 STOP: at cnt==0, rxs==1 -> push byte, -> IDLE; rxs==0 -> discard byte, pulse o_frame_err, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rxs==1, then -> IDLE (break condition never starts a new frame).
REQ-018 Pop occurs when o_valid && i_ready; o_data/o_valid update on next edge.
REQ-019 Push with buffer full and no pop in same cycle SHALL drop the new byte, keep stored data, pulse o_overrun.
REQ-020 Push and pop in same cycle with buffer full SHALL accept the push, no overrun.
REQ-021 o_valid SHALL rise the cycle after the stop-bit sample; latency from pin falling edge = 2 + DIV/2 + 9*DIV cycles (+/-1).
REQ-022 o_data SHALL be stable while o_valid high and no pop occurs.

Reset
REQ-023 resetn low SHALL asynchronously force state IDLE, cnt 0, index 0, buffer empty, synchronizer flops 1.
REQ-024 Outputs under reset: o_data 0x00, o_valid 0, o_frame_err 0, o_overrun 0.
REQ-025 Reset mid-frame SHALL abort the frame; no partial byte, no error pulse after release.

Configuration
REQ-026 Macro UART_RX_FIFO_EN SHALL select buffering.
REQ-027 Without UART_RX_FIFO_EN: single holding register; full = o_valid.
REQ-028 With UART_RX_FIFO_EN: 4-entry FIFO, 2-bit wrapping read/write pointers plus 3-bit count; o_data = head; full at count 4; o_valid = count != 0.

Verification
REQ-029 Defaults, send 0x55 at 9600 baud, i_ready=1 -> o_valid one cycle, o_data=0x55, ~11877 cycles after start edge.
REQ-030 i_ready=0, send 0xA5 then 0x3C (no FIFO) -> o_data stays 0xA5, o_overrun pulses once at 0x3C stop sample.
REQ-031 Send 0x81 with stop bit 0, line held low 3 bit times -> o_frame_err one pulse, o_valid stays 0, no new frame until line high.
REQ-032 Low glitch of 300 cycles on idle line -> returns to IDLE, no o_valid, no error pulses.
REQ-033 Assert resetn low during DATA bit 4 of 0xF0, release, send 0x12 -> only 0x12 delivered.
REQ-034 With UART_RX_FIFO_EN, i_ready=0, send 0x01..0x05 -> o_overrun on 0x05 only; then i_ready=1 pops 0x01,0x02,0x03,0x04 in order, o_valid falls after 4th pop.
